// File: rtl/argmax_unit.sv
// Final classification stage: scans the FC2 logit memory and reports the winning
// class, the top two logits, their margin and a low-confidence flag on a valid/ready port.
module argmax_unit #(
  parameter int          OUT_DIM       = 10,
  parameter logic [31:0] MARGIN_THRESH = 32'd0,
  localparam int         AW            = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               y_re,
  output logic [AW-1:0]      y_addr,
  input  logic signed [31:0] y_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AW-1:0]      class_idx,
  output logic signed [31:0] max_logit,
  output logic signed [31:0] second_logit,
  output logic [31:0]        margin,
  output logic               low_conf
);
  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic [AW-1:0]      LAST      = AW'(OUT_DIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_RESULT} state_t;

  state_t             state_q;
  logic               vld_p1_q;
  logic [AW-1:0]      idx_p1_q;
  logic signed [31:0] best_q;
  logic signed [31:0] second_q;
  logic [AW-1:0]      bidx_q;

  // best >= second always, so the exact 33-bit difference lies in [0, 2^32-1]
  // and its low 32 bits are the full unsigned margin.
  function automatic logic [31:0] calc_margin(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    logic signed [32:0] d;
    d = {a[31], a} - {b[31], b};
    return d[31:0];
  endfunction

  function automatic logic below_thresh(input logic [31:0] m);
    return $signed({1'b0, m}) < $signed({1'b0, MARGIN_THRESH});
  endfunction

  // Stage p1: read data arrives with its tag; strictly-greater replacement keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    idx_p1_q <= y_addr;
    if (vld_p1_q) begin
      if (idx_p1_q == '0) begin
        best_q   <= y_data;
        bidx_q   <= '0;
        second_q <= INT32_MIN;
      end else if (y_data > best_q) begin
        second_q <= best_q;
        best_q   <= y_data;
        bidx_q   <= idx_p1_q;
      end else if (y_data > second_q) begin
        second_q <= y_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vld_p1_q     <= 1'b0;
      busy         <= 1'b0;
      y_re         <= 1'b0;
      y_addr       <= '0;
      out_valid    <= 1'b0;
      class_idx    <= '0;
      max_logit    <= '0;
      second_logit <= '0;
      margin       <= '0;
      low_conf     <= 1'b0;
    end else begin
      vld_p1_q <= y_re;
      case (state_q)
        S_IDLE: begin
          if (start && !out_valid) begin
            y_addr  <= '0;
            y_re    <= 1'b1;
            busy    <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (y_addr == LAST) begin
            y_re    <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            y_addr <= y_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          // Tag clear means the final datum was folded in on the previous edge.
          if (!vld_p1_q) begin
            class_idx    <= bidx_q;
            max_logit    <= best_q;
            second_logit <= second_q;
            margin       <= calc_margin(best_q, second_q);
            low_conf     <= below_thresh(calc_margin(best_q, second_q));
            out_valid    <= 1'b1;
            busy         <= 1'b0;
            state_q      <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_argmax_unit.sv
// Randomized and directed bench for argmax_unit with a registered logit memory model
// and an array-based reference for class/top-two/margin.
module tb_argmax_unit;
  localparam int          N   = 10;
  localparam logic [31:0] THR = 32'd1;
  localparam logic signed [31:0] IMIN = 32'sh8000_0000;
  localparam logic signed [31:0] IMAX = 32'sh7FFF_FFFF;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               busy;
  logic               y_re;
  logic [3:0]         y_addr;
  logic signed [31:0] y_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [3:0]         class_idx;
  logic signed [31:0] max_logit;
  logic signed [31:0] second_logit;
  logic [31:0]        margin;
  logic               low_conf;

  argmax_unit #(.OUT_DIM(N), .MARGIN_THRESH(THR)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .y_re(y_re), .y_addr(y_addr),
    .y_data(y_data), .out_valid(out_valid), .out_ready(out_ready), .class_idx(class_idx),
    .max_logit(max_logit), .second_logit(second_logit), .margin(margin), .low_conf(low_conf)
  );

  always #5 clk = ~clk;

  logic signed [31:0] mem [N];
  int   checks = 0;
  int   failures = 0;
  int   reads = 0;
  int   seq_err = 0;
  logic prev_re = 1'b0;
  logic [3:0] prev_addr = '0;

  // Registered-read logit memory plus a read counter and address-sequence monitor.
  always @(posedge clk) begin
    if (y_re) begin
      y_data <= (y_addr < N) ? mem[y_addr] : 32'sd0;
      reads  <= reads + 1;
      if (prev_re ? (int'(y_addr) != int'(prev_addr) + 1) : (y_addr != 4'd0))
        seq_err <= seq_err + 1;
    end
    prev_re   <= y_re;
    prev_addr <= y_addr;
  end

  int                 e_idx;
  logic signed [31:0] e_max, e_sec;
  logic [31:0]        e_mg;
  logic               e_lc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (out_valid) begin
        lat = c;
        return;
      end
    end
  endtask

  // Reference: winner is the first occurrence of the maximum; runner-up is the
  // largest value among all other positions (INT32_MIN if none).
  task automatic model();
    longint diff;
    e_idx = 0;
    for (int i = 1; i < N; i++) if (mem[i] > mem[e_idx]) e_idx = i;
    e_max = mem[e_idx];
    e_sec = IMIN;
    for (int i = 0; i < N; i++) if (i != e_idx && mem[i] > e_sec) e_sec = mem[i];
    diff = longint'(e_max) - longint'(e_sec);
    e_mg = diff[31:0];
    e_lc = diff < longint'(THR);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, y_re, out_valid, low_conf} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000", {busy, y_re, out_valid, low_conf});
    end
    checks++;
    if ({class_idx, max_logit, second_logit, margin} !== 100'd0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0", {class_idx, max_logit, second_logit, margin});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, r0;
    logic signed [31:0] v [N] = '{3, -7, 12, 0, 5, 11, -1, 2, 9, 4};
    for (int i = 0; i < N; i++) mem[i] = v[i];
    out_ready = 1'b1;
    r0 = reads;
    launch();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_valid(lat);
    checks++;
    if (lat != 12) begin failures++; $display("FAIL basic_latency: got %0d want 12", lat); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_done: got %b want 0", busy); end
    checks++;
    if ({class_idx, max_logit, second_logit, margin, low_conf} !== {4'd2, 32'sd12, 32'sd11, 32'd1, 1'b0}) begin
      failures++;
      $display("FAIL basic_result: got %h want %h", {class_idx, max_logit, second_logit, margin, low_conf},
               {4'd2, 32'sd12, 32'sd11, 32'd1, 1'b0});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_1cyc: got %b want 0", out_valid); end
    checks++;
    if (reads - r0 != N || seq_err != 0) begin
      failures++;
      $display("FAIL basic_reads: got %0d reads seq_err %0d want %0d reads seq_err 0", reads - r0, seq_err, N);
    end
  endtask

  task automatic test_tie();
    int lat;
    for (int i = 0; i < N; i++) mem[i] = 32'sd1;
    mem[0] = 32'sd5; mem[1] = 32'sd9; mem[2] = 32'sd9;
    launch();
    wait_valid(lat);
    checks++;
    if (lat != 12 || {class_idx, max_logit, second_logit, margin, low_conf} !== {4'd1, 32'sd9, 32'sd9, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL tie_result: got lat %0d %h want lat 12 %h", lat,
               {class_idx, max_logit, second_logit, margin, low_conf}, {4'd1, 32'sd9, 32'sd9, 32'd0, 1'b1});
    end
    tick();
  endtask

  task automatic test_extremes();
    int lat;
    for (int i = 0; i < N; i++) mem[i] = IMIN;
    mem[7] = IMAX;
    launch();
    wait_valid(lat);
    checks++;
    if (lat != 12 || {class_idx, max_logit, second_logit, margin, low_conf} !== {4'd7, IMAX, IMIN, 32'hFFFF_FFFF, 1'b0}) begin
      failures++;
      $display("FAIL extreme_result: got lat %0d %h want lat 12 %h", lat,
               {class_idx, max_logit, second_logit, margin, low_conf}, {4'd7, IMAX, IMIN, 32'hFFFF_FFFF, 1'b0});
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat, r0;
    bit saw;
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    model();
    out_ready = 1'b0;
    r0 = reads;
    launch();
    wait_valid(lat);
    checks++;
    if (lat != 12) begin failures++; $display("FAIL bp_latency: got %0d want 12", lat); end
    for (int k = 0; k < 5; k++) begin
      if (k == 1) start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || y_re !== 1'b0 ||
          {class_idx, max_logit, second_logit, margin, low_conf} !== {4'(e_idx), e_max, e_sec, e_mg, e_lc}) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d got vld %b re %b %h want vld 1 re 0 %h", k, out_valid, y_re,
                 {class_idx, max_logit, second_logit, margin, low_conf}, {4'(e_idx), e_max, e_sec, e_mg, e_lc});
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_accept: got %b want 0", out_valid); end
    saw = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (out_valid || y_re) saw = 1'b1;
    end
    checks++;
    if (saw || reads - r0 != N) begin
      failures++;
      $display("FAIL bp_no_rescan: got activity %b reads %0d want activity 0 reads %0d", saw, reads - r0, N);
    end
  endtask

  task automatic test_restart_midscan();
    int lat, r0;
    bit saw;
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    model();
    r0 = reads;
    launch();
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat != 9 || {class_idx, max_logit, second_logit, margin, low_conf} !== {4'(e_idx), e_max, e_sec, e_mg, e_lc}) begin
      failures++;
      $display("FAIL restart_result: got lat %0d %h want lat 9 %h", lat,
               {class_idx, max_logit, second_logit, margin, low_conf}, {4'(e_idx), e_max, e_sec, e_mg, e_lc});
    end
    saw = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (out_valid || y_re) saw = 1'b1;
    end
    checks++;
    if (saw || reads - r0 != N) begin
      failures++;
      $display("FAIL restart_single: got activity %b reads %0d want activity 0 reads %0d", saw, reads - r0, N);
    end
  endtask

  task automatic test_reset_midscan();
    int lat;
    bit saw;
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    launch();
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, y_re, out_valid, low_conf} !== 4'b0 || {class_idx, max_logit, second_logit, margin} !== 100'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got %b %h want 0000 0", {busy, y_re, out_valid, low_conf},
               {class_idx, max_logit, second_logit, margin});
    end
    rst = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid || y_re) saw = 1'b1;
    end
    checks++;
    if (saw) begin failures++; $display("FAIL midreset_abort: got activity 1 want 0"); end
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    model();
    launch();
    wait_valid(lat);
    checks++;
    if (lat != 12 || {class_idx, max_logit, second_logit, margin, low_conf} !== {4'(e_idx), e_max, e_sec, e_mg, e_lc}) begin
      failures++;
      $display("FAIL midreset_rescan: got lat %0d %h want lat 12 %h", lat,
               {class_idx, max_logit, second_logit, margin, low_conf}, {4'(e_idx), e_max, e_sec, e_mg, e_lc});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, r0, dly;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) begin
        case (it % 3)
          0: mem[i] = $urandom;
          1: mem[i] = int'($urandom_range(0, 6)) - 3;
          default: mem[i] = ($urandom_range(0, 1) == 1) ? IMAX - int'($urandom_range(0, 2))
                                                          : IMIN + int'($urandom_range(0, 2));
        endcase
      end
      model();
      dly = $urandom_range(0, 3);
      out_ready = (dly == 0);
      r0 = reads;
      launch();
      wait_valid(lat);
      checks++;
      if (lat != 12 || {class_idx, max_logit, second_logit, margin, low_conf} !== {4'(e_idx), e_max, e_sec, e_mg, e_lc}) begin
        failures++;
        $display("FAIL b2b_result[%0d]: got lat %0d %h want lat 12 %h", it, lat,
                 {class_idx, max_logit, second_logit, margin, low_conf}, {4'(e_idx), e_max, e_sec, e_mg, e_lc});
      end
      for (int k = 0; k < dly; k++) begin
        tick();
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_hold[%0d]: got %b want 1", it, out_valid); end
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || reads - r0 != N || seq_err != 0) begin
        failures++;
        $display("FAIL b2b_accept[%0d]: got vld %b reads %0d seq_err %0d want vld 0 reads %0d seq_err 0",
                 it, out_valid, reads - r0, seq_err, N);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_extremes();
    test_backpressure();
    test_restart_midscan();
    test_reset_midscan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
